// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data memory responder: FSM state encoding,
// default geometry/latency and the wait-counter width.
// ----------------------------------------------------------------------------
package mem_pkg;

  localparam int DEPTH_DEF   = 256;  // 32-bit words of storage
  localparam int LATENCY_DEF = 3;    // stall cycles per request (1..15)
  localparam int CNT_W       = 4;    // wait counter width, holds LATENCY-1

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
// MEM-stage data bus between the pipeline (master) and the memory responder
// (slave).
//   memRead/memWrite : access request, held stable while stall is high
//   address          : byte address, word aligned for a clean access
//   writeData        : store data
//   readData         : registered load data
//   stall            : pipeline freeze request
//   addrError        : misaligned or read+write conflict on current request
// ----------------------------------------------------------------------------
interface data_mem_responder_if;

  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        stall;
  logic        addrError;

  modport master (
    output memRead, memWrite, address, writeData,
    input  readData, stall, addrError
  );

  modport slave (
    input  memRead, memWrite, address, writeData,
    output readData, stall, addrError
  );

endinterface

// File: rtl/data_mem_responder_wait_counter.sv
// ----------------------------------------------------------------------------
// wait_counter
// Loadable down-counter timing the BUSY phase of a memory access.
//   clk, rst : clock, synchronous active-high reset (clears to 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; saturates at 0
//   count    : current value
//   zero     : count is 0
// ----------------------------------------------------------------------------
module wait_counter
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                       cnt_q <= '0;
    else if (load)                 cnt_q <= load_val;
    else if (dec && cnt_q != '0)   cnt_q <= cnt_q - CNT_W'(1);
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Multi-cycle data memory for the MEM pipeline stage. Every access stalls the
// pipeline for LATENCY cycles (IDLE -> BUSY... -> DONE), then completes in the
// DONE cycle with stall low.
//   clk  : clock, rising-edge
//   rst  : synchronous active-high reset; clears FSM, counter, readData and
//          every storage word, and drops any pending write
//   bus  : data_mem_responder_if.slave (request in, readData/stall/addrError
//          out)
// Parameters:
//   DEPTH   : words of storage, power of two; address bits above the word
//             index are ignored so accesses wrap
//   LATENCY : stall cycles per access, 1..15
// Read data is captured on the edge entering DONE; write data is committed on
// the edge leaving DONE, so a reset during BUSY or DONE never commits.
// ----------------------------------------------------------------------------
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int IDXW = $clog2(DEPTH);

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic            req;
  logic [IDXW-1:0] idx;
  logic            unused_addr;

  assign req = bus.memRead | bus.memWrite;
  assign idx = bus.address[IDXW+1:2];

  // Upper address bits only exist to be ignored (modulo-DEPTH wrap).
  assign unused_addr = ^bus.address[31:IDXW+2];

  // --------------------------------------------------------------------------
  // FSM + wait counter
  // --------------------------------------------------------------------------
  state_e           state_q, state_n;
  logic             cnt_load, cnt_dec, enter_done;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(LATENCY - 1)),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n    = state_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_load = 1'b1;
          if (LATENCY == 1) begin
            state_n    = DONE;
            enter_done = 1'b1;
          end else begin
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_dec = 1'b1;
        // Leave on the edge where the counter drops to 0. The zero term only
        // guards against a counter that is already empty.
        if (cnt == CNT_W'(1) || cnt_zero) begin
          state_n    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.stall     = (state_q == IDLE && req) || (state_q == BUSY);
  assign bus.addrError = req && ((bus.memRead && bus.memWrite) ||
                                 (bus.address[1:0] != 2'b00));

  // --------------------------------------------------------------------------
  // Storage and access capture
  // --------------------------------------------------------------------------
  logic [31:0]     mem [DEPTH];
  logic [31:0]     rdata_q;
  logic            wr_pend_q;
  logic [IDXW-1:0] wr_idx_q;
  logic [31:0]     wr_data_q;

  // A read+write conflict is executed as a write, so readData is untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else if (enter_done) begin
      wr_pend_q <= bus.memWrite;
      wr_idx_q  <= idx;
      wr_data_q <= bus.writeData;
      if (bus.memRead && !bus.memWrite) rdata_q <= mem[idx];
    end else if (state_q == DONE) begin
      wr_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_q == DONE && wr_pend_q) begin
      mem[wr_idx_q] <= wr_data_q;
    end
  end

  assign bus.readData = rdata_q;

endmodule
